// File: rtl/param_ram.sv
// Single-port word RAM with byte-lane writes, registered reads and a self-clearing sweep.
// The array is zeroed one word per cycle after reset and whenever clr is requested.
module param_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic [LANES-1:0]    wr_lane;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;

  assign old_word = mem[addr];

  // Word as it will look after this cycle's write; used for write-first reads.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
    assign merged_word[8*gi +: 8] = (we && be[gi]) ? data_in[8*gi +: 8] : old_word[8*gi +: 8];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_addr    = addr;
    wr_data    = data_in;
    wr_lane    = '0;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_addr = ptr_q;
        wr_data = '0;
        wr_lane = '1;
        ptr_d   = ptr_q + ADDR_W'(1);
        if (clr) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else begin
          if (we) wr_lane = be;
          if (re) begin
            rd_valid_d = 1'b1;
            data_out_d = (RDW_MODE == 1) ? merged_word : old_word;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // No reset on the array so it maps onto block RAM; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_param_ram.sv
// Checks two 16-bit param_ram instances (read-first and write-first) against a
// cycle-level behavioural model, plus directed literal scenarios.
module tb_param_ram;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int LANES = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          we  = 1'b0;
  logic          re  = 1'b0;
  logic [1:0]    be  = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout0, dout1;
  logic          valid0, valid1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int            busy_left = 0;
  logic [DW-1:0] mmem [DEPTH];
  logic [DW-1:0] exp_dout0 = '0;
  logic [DW-1:0] exp_dout1 = '0;
  logic          exp_valid = 1'b0;
  bit            model_ok = 1'b0;

  always #5 clk = ~clk;

  param_ram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) u_rf (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .re(re), .addr(addr),
    .data_in(din), .data_out(dout0), .rd_valid(valid0), .busy(busy0)
  );

  param_ram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) u_wf (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .re(re), .addr(addr),
    .data_in(din), .data_out(dout1), .rd_valid(valid1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a sweep is just "busy for DEPTH more edges, array reads as zero afterwards".
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        busy_left = DEPTH;
        exp_dout0 = '0;
        exp_dout1 = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        model_ok = 1'b1;
      end else if (busy_left > 0) begin
        exp_valid = 1'b0;
        if (clr) busy_left = DEPTH;
        else     busy_left = busy_left - 1;
      end else if (clr) begin
        busy_left = DEPTH;
        exp_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      end else begin
        logic [DW-1:0] old_w, new_w;
        old_w = mmem[addr];
        new_w = old_w;
        if (we) begin
          for (int l = 0; l < LANES; l++)
            if (be[l]) new_w[8*l +: 8] = din[8*l +: 8];
        end
        mmem[addr] = new_w;
        exp_valid = re;
        if (re) begin
          exp_dout0 = old_w;
          exp_dout1 = new_w;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("m_busy_rf",  busy0,  busy_left > 0);
        chk("m_busy_wf",  busy1,  busy_left > 0);
        chk("m_valid_rf", valid0, exp_valid);
        chk("m_valid_wf", valid1, exp_valid);
        chk("m_dout_rf",  dout0,  exp_dout0);
        chk("m_dout_wf",  dout1,  exp_dout1);
      end
    end
  end

  task automatic cyc(input logic c, input logic w, input logic r, input logic [1:0] b,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr = c; we = w; re = r; be = b; addr = a; din = d;
    @(posedge clk);
    #1;
    $display("txn clr=%0d we=%0d re=%0d be=%b addr=%0d din=%h | busy=%0d v=%0d d_rf=%h d_wf=%h",
             c, w, r, b, a, d, busy0, valid0, dout0, dout1);
    clr = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic release_rst;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  int n;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 1);
    chk("rst_dout", dout0, 0);
    chk("rst_valid", valid0, 0);
    release_rst();
    wait_idle(n);
    chk("sweep_len_reset", n, 8);

    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 1, 2'b00, AW'(i), '0);
      chk("read_zero", dout0, 0);
      chk("read_zero_valid", valid0, 1);
    end
    cyc(0, 0, 0, 2'b00, '0, '0);
    chk("valid_drop", valid0, 0);

    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 2'b11, AW'(i), DW'(i * 8 + 16));
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 1, 2'b00, AW'(i), '0);
      chk("read_pattern", dout0, DW'(i * 8 + 16));
    end
    cyc(0, 0, 1, 2'b00, 3'd7, '0);
    chk("read_addr7_lit", dout0, 16'h0048);

    cyc(0, 1, 0, 2'b11, 3'd2, 16'hABCD);
    cyc(0, 1, 0, 2'b01, 3'd2, 16'h1234);
    cyc(0, 0, 1, 2'b00, 3'd2, '0);
    chk("byte_en_rf", dout0, 16'hAB34);
    chk("byte_en_wf", dout1, 16'hAB34);

    cyc(0, 1, 0, 2'b11, 3'd5, 16'h0011);
    cyc(0, 1, 1, 2'b11, 3'd5, 16'h0022);
    chk("rdw_rf", dout0, 16'h0011);
    chk("rdw_wf", dout1, 16'h0022);
    cyc(0, 0, 1, 2'b00, 3'd5, '0);
    chk("rdw_later", dout0, 16'h0022);

    cyc(0, 1, 1, 2'b10, 3'd3, 16'h7700);
    chk("rdw_part_rf", dout0, 16'h0028);
    chk("rdw_part_wf", dout1, 16'h7728);
    cyc(0, 1, 0, 2'b00, 3'd3, 16'hFFFF);
    chk("hold_dout", dout1, 16'h7728);
    cyc(0, 0, 1, 2'b00, 3'd3, '0);
    chk("be_zero_write", dout0, 16'h7728);

    cyc(1, 1, 1, 2'b11, 3'd1, 16'hFFFF);
    chk("clr_busy", busy0, 1);
    chk("clr_no_read", valid0, 0);
    wait_idle(n);
    chk("sweep_len_clr", n, 8);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 1, 2'b00, AW'(i), '0);
      chk("clr_read_zero", dout0, 0);
    end

    cyc(0, 1, 0, 2'b11, 3'd4, 16'h1111);
    cyc(1, 0, 0, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 2'b11, 3'd4, 16'h5555);
      chk("busy_ignore_valid", valid0, 0);
    end
    cyc(1, 0, 0, 2'b00, '0, '0);
    wait_idle(n);
    chk("sweep_restart_len", n, 8);
    cyc(0, 0, 1, 2'b00, 3'd4, '0);
    chk("busy_write_ignored", dout0, 0);

    cyc(0, 1, 0, 2'b11, 3'd6, 16'h6666);
    cyc(0, 0, 1, 2'b00, 3'd6, '0);
    chk("pre_rst_read", dout0, 16'h6666);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy0, 1);
    chk("async_rst_dout", dout0, 0);
    chk("async_rst_valid", valid0, 0);
    release_rst();
    wait_idle(n);
    chk("sweep_len_rst_read", n, 8);

    cyc(0, 1, 0, 2'b11, 3'd6, 16'h6666);
    cyc(1, 0, 0, 2'b00, '0, '0);
    cyc(0, 0, 0, 2'b00, '0, '0);
    cyc(0, 0, 0, 2'b00, '0, '0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mid_sweep", busy0, 1);
    release_rst();
    wait_idle(n);
    chk("sweep_len_rst_sweep", n, 8);
    cyc(0, 0, 1, 2'b00, 3'd6, '0);
    chk("rst_sweep_cleared", dout0, 0);

    for (int k = 0; k < 600; k++) begin
      if (k == 300) begin
        #2 rst = 1'b1;
        release_rst();
      end
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
          AW'($urandom), DW'($urandom));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
